abnormality_event_logger: RTL
=============================

ABNORMALITY_EVENT_LOGGER -- requirements
Module: abnormality_event_logger

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2, consecutive high samples a source bit needs before it counts as asserted (range 1..15).
REQ-002 Parameter FIFO_DEPTH, default 8, number of event records buffered (power of two).
REQ-003 Parameter TS_WIDTH, default 16, width of the free-running timestamp counter.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 abnormality_vector  input  6  per-source flags from the healthcare top level: bit4 pressure, bit3 blood, bit2 fall, bit1 temperature, bit0 nervous; bit5 reserved and ignored.
REQ-007 abnormality_warning  input  3  current severity level from the healthcare controller.
REQ-008 event_ready  input  1  consumer accepts the head record when high together with event_valid.
REQ-009 clear_overflow  input  1  one-cycle pulse clearing overflow and drop_count.
REQ-010 event_valid  output  1  head record present on event_data.
REQ-011 event_data  output  TS_WIDTH+8  record: [TS_WIDTH+7:8] timestamp, [7:5] severity, [4:0] rise mask.
REQ-012 event_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-013 overflow  output  1  sticky flag, a record was dropped.
REQ-014 drop_count  output  8  number of dropped records, saturating.

Function
REQ-015 The timestamp counter SHALL increment by 1 every cycle and wrap from all-ones to 0.
REQ-016 Each source bit SHALL have a debouncer: debounced bit rises on the edge where the raw bit has been sampled high DEBOUNCE_CYCLES consecutive times; it falls on the first edge sampling raw low; the run counter restarts on any low sample.
REQ-017 Rise mask SHALL be the set of debounced bits that rose on the current edge; multiple simultaneous rises SHALL form one record, not several.
REQ-018 A non-zero rise mask SHALL push one record on the next edge, carrying that mask, the abnormality_warning sampled on the rise edge, and the timestamp value at the rise edge.
REQ-019 Latency: raw bit first sampled high at edge k with FIFO empty SHALL give event_valid high after edge k+DEBOUNCE_CYCLES.
REQ-020 A source held high SHALL produce exactly one record; a new record for it requires a debounced fall and a fresh rise.
REQ-021 Handshake: a record pops on an edge where event_valid and event_ready are both high; event_data SHALL be stable while event_valid is high and event_ready low.
REQ-022 event_valid SHALL equal (event_count != 0); event_data is don't-care when event_valid is low.
REQ-023 Push and pop on the same edge SHALL both occur, occupancy unchanged, including when full and when empty-with-bypass is not used (an empty FIFO never pops).
REQ-024 Push while full without a simultaneous pop SHALL drop the new record, set overflow, and increment drop_count saturating at 255.
REQ-025 clear_overflow SHALL clear overflow and drop_count on that edge; a drop on the same edge SHALL win (overflow=1, drop_count=1).
REQ-026 FIFO order SHALL be strictly first-in first-out; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 Reset SHALL force, asynchronously: timestamp 0, all debouncers and run counters 0, FIFO empty, event_valid 0, event_count 0, overflow 0, drop_count 0, event_data 0.
REQ-028 Reset mid-operation SHALL discard all buffered records; a source still high after reset release SHALL be treated as a fresh rise and re-debounced.

Structure
REQ-029 A shared healthcare package SHALL hold source bit indices, record field positions/widths, and severity width constant.
REQ-030 A single sub-module event_fifo (parameterised sync FIFO, push/pop/full/empty/count) SHALL hold storage; debounce, rise detection and overflow logic stay in the top.

Verification
REQ-031 Fall bit raised at edge 10 after reset, warning=3'b010, FIFO empty, event_ready=0 -> event_valid high after edge 12, event_data = {timestamp at edge 11, 3'b010, 5'b00100}.
REQ-032 Nervous bit pulsed high for 1 cycle with DEBOUNCE_CYCLES=2 -> no record, event_count stays 0.
REQ-033 Pressure and temperature rise on the same cycle -> one record with mask 5'b10010; held high 100 cycles -> still one record.
REQ-034 event_ready=0, 10 distinct rises -> event_count=8, overflow=1, drop_count=2; then event_ready=1 drains 8 records in push order; clear_overflow -> overflow=0, drop_count=0.
REQ-035 FIFO full, push and pop on same edge -> event_count stays 8, no drop, overflow unchanged.
REQ-036 Assert reset with 5 records buffered and a source high -> all outputs 0 immediately; after release, record for that source appears after DEBOUNCE_CYCLES+1 edges.

Source files
------------

// File: rtl/abnormality_event_logger_pkg.sv
// Shared healthcare definitions: source bit positions, event record layout
// and severity width used by the abnormality event logger.
package abnormality_event_logger_pkg;

    typedef enum logic [2:0] {
        SRC_NERVOUS     = 3'd0,
        SRC_TEMPERATURE = 3'd1,
        SRC_FALL        = 3'd2,
        SRC_BLOOD       = 3'd3,
        SRC_PRESSURE    = 3'd4,
        SRC_RESERVED    = 3'd5
    } src_idx_e;

    localparam int unsigned VEC_W   = 6;
    localparam int unsigned NUM_SRC = 5;
    localparam int unsigned SEV_W   = 3;

    // Record layout, LSB first: rise mask, severity, then timestamp on top.
    localparam int unsigned REC_MASK_LSB = 0;
    localparam int unsigned REC_MASK_W   = NUM_SRC;
    localparam int unsigned REC_SEV_LSB  = REC_MASK_LSB + REC_MASK_W;
    localparam int unsigned REC_TS_LSB   = REC_SEV_LSB + SEV_W;

    localparam int unsigned DROP_W = 8;

endpackage

// File: rtl/abnormality_event_logger_fifo.sv
// event_fifo: synchronous first-in first-out record store with occupancy
// count; a push while full is accepted only when a pop happens on the same edge.
module event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_fire;
    logic             pop_fire;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == DEPTH_C);
        pop_fire  = pop & ~empty;
        // A pop frees the slot the incoming record needs when full.
        push_fire = push & (~full | pop_fire);

        mem_d = mem_q;
        if (push_fire) begin
            mem_d[wr_ptr_q] = wdata;
        end

        wr_ptr_d = wr_ptr_q + AW'(push_fire);
        rd_ptr_d = rd_ptr_q + AW'(pop_fire);
        count_d  = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/abnormality_event_logger.sv
// Debounces per-source abnormality flags, turns debounced rises into
// timestamped records and buffers them for a valid/ready consumer.
module abnormality_event_logger
    import abnormality_event_logger_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned TS_WIDTH        = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [VEC_W-1:0]                 abnormality_vector,
    input  logic [SEV_W-1:0]                 abnormality_warning,
    input  logic                             event_ready,
    input  logic                             clear_overflow,
    output logic                             event_valid,
    output logic [TS_WIDTH+REC_TS_LSB-1:0]   event_data,
    output logic [$clog2(FIFO_DEPTH):0]      event_count,
    output logic                             overflow,
    output logic [DROP_W-1:0]                drop_count
);

    localparam int unsigned REC_W = TS_WIDTH + REC_TS_LSB;
    localparam logic [3:0]  DEB_N = 4'(DEBOUNCE_CYCLES);

    logic [NUM_SRC-1:0][3:0] run_q, run_d;
    logic [NUM_SRC-1:0]      deb_q, deb_d;
    logic [NUM_SRC-1:0]      rise_mask;
    logic [TS_WIDTH-1:0]     ts_q, ts_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [REC_W-1:0]        pend_rec_q, pend_rec_d;
    logic                    overflow_q, overflow_d;
    logic [DROP_W-1:0]       drop_count_q, drop_count_d;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    drop;
    logic                    unused_reserved_bit;

    assign unused_reserved_bit = abnormality_vector[SRC_RESERVED];

    // Run counter saturates at the threshold, so "debounced" is simply run == N.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            run_d[i] = '0;
            if (abnormality_vector[i]) begin
                run_d[i] = (run_q[i] < DEB_N) ? run_q[i] + 4'd1 : run_q[i];
            end
            deb_d[i] = (run_d[i] == DEB_N);
        end
        rise_mask = deb_d & ~deb_q;
    end

    always_comb begin
        ts_d         = ts_q + TS_WIDTH'(1);
        pend_valid_d = |rise_mask;
        pend_rec_d   = {ts_q, abnormality_warning, rise_mask};
    end

    // A full FIFO only refuses the pending record when nothing leaves this edge.
    always_comb begin
        drop         = pend_valid_q & fifo_full & ~event_ready;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow) begin
                drop_count_d = DROP_W'(1);
            end else if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + DROP_W'(1);
            end
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q        <= '0;
            deb_q        <= '0;
            ts_q         <= '0;
            pend_valid_q <= 1'b0;
            pend_rec_q   <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            run_q        <= run_d;
            deb_q        <= deb_d;
            ts_q         <= ts_d;
            pend_valid_q <= pend_valid_d;
            pend_rec_q   <= pend_rec_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_event_fifo (
        .clk   (clock),
        .rst   (reset),
        .push  (pend_valid_q),
        .pop   (event_ready),
        .wdata (pend_rec_q),
        .rdata (event_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (event_count)
    );

    assign event_valid = ~fifo_empty;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;

endmodule
